inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2, SHALL be the instruction buffer entry count (legal: 2..8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 redirect_valid  input  1  SHALL request a fetch-PC change (branch/jump) this cycle.
REQ-006 redirect_pc  input  32  SHALL give the new fetch address, sampled when redirect_valid=1.
REQ-007 imem_req  output  1  SHALL request an instruction-memory read.
REQ-008 imem_addr  output  32  SHALL give the read address; it SHALL be valid whenever imem_req=1.
REQ-009 imem_ack  input  1  SHALL complete the current read; it SHALL be ignored when imem_req=0.
REQ-010 imem_rdata  input  32  SHALL give the read data, sampled in the imem_ack cycle.
REQ-011 inst_valid  output  1  SHALL be high when the buffer head holds an instruction.
REQ-012 inst_pc  output  32  SHALL give the address of the head instruction.
REQ-013 inst_data  output  32  SHALL give the head instruction word.
REQ-014 inst_ready  input  1  SHALL be driven by the consumer; a pop SHALL occur when inst_valid=1 and inst_ready=1.

Function
REQ-015 The block SHALL hold a 32-bit fetch_pc, an FSM {IDLE, REQ, DRAIN}, and a DEPTH-entry FIFO of {pc, data} pairs with a count register.
REQ-016 The block SHALL have at most one memory read outstanding.
REQ-017 imem_req SHALL be 1 exactly in states REQ and DRAIN; imem_addr SHALL be stable from request until ack.
REQ-018 imem_addr SHALL equal fetch_pc in REQ and the abandoned address in DRAIN.
REQ-019 IDLE -> REQ SHALL occur when count < DEPTH and redirect_valid=0.
REQ-020 On imem_ack in REQ without redirect, the block SHALL push {fetch_pc, imem_rdata} and set fetch_pc to fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 After that push, the FSM SHALL stay in REQ if the post-push/post-pop count < DEPTH, else go to IDLE; back-to-back requests SHALL therefore have zero idle cycles.
REQ-022 A simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur when count=DEPTH.
REQ-023 inst_valid SHALL equal (count != 0); inst_pc and inst_data SHALL come from the head entry (registered storage, no imem_rdata bypass), so the minimum ack-to-inst_valid latency is 1 cycle.
REQ-024 On redirect_valid=1, fetch_pc SHALL load redirect_pc, the FIFO SHALL be flushed (count=0), and a same-cycle pop SHALL be discarded.
REQ-025 Redirect in REQ without imem_ack SHALL move the FSM to DRAIN, which holds the old request until ack and then discards the data.
REQ-026 Redirect in the same cycle as imem_ack in REQ SHALL discard the data, and the FSM SHALL go to IDLE.
REQ-027 Redirect while in DRAIN SHALL update fetch_pc only; the FSM SHALL remain in DRAIN until ack.
REQ-028 imem_ack in DRAIN SHALL move the FSM to IDLE, with no push.
REQ-029 Redirect in IDLE SHALL update fetch_pc and flush, staying in IDLE for that cycle.
REQ-030 redirect_pc[1:0] SHALL be used as given; alignment is the producer's responsibility.

Reset
REQ-031 While RST_n=0: fetch_pc=RESET_PC, FSM=IDLE, count=0, imem_req=0, inst_valid=0; inst_pc and inst_data SHALL be 0.
REQ-032 Reset assertion mid-transaction SHALL abandon any outstanding read with no later push.
REQ-033 The first imem_req=1 SHALL appear in the second cycle after RST_n rises (IDLE -> REQ), with imem_addr=RESET_PC.

Verification
REQ-034 Reset release, imem_ack=1 every cycle, inst_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; inst_pc follows one cycle behind each ack with matching imem_rdata.
REQ-035 inst_ready=0, ack always 1 -> exactly DEPTH=2 entries (pc 0,4) are buffered; imem_req drops; raising inst_ready resumes fetch at 8.
REQ-036 Request at 0x10, ack delayed 3 cycles, redirect to 0x200 in the 1st wait cycle -> imem_addr holds 0x10 until ack, data is discarded, the next request is at 0x200, and the first inst_pc is 0x200.
REQ-037 Redirect to 0x40 in the same cycle as an ack and a pop with count=2 -> count=0, no push, FSM IDLE, the next request is at 0x40.
REQ-038 fetch_pc=32'hFFFF_FFFC and ack -> inst_pc=0xFFFF_FFFC, next imem_addr=0.
REQ-039 RST_n pulsed low while in DRAIN -> all outputs at reset values immediately; after release, fetch restarts at RESET_PC with no stale entry.

Source files
------------

// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
// inst_fetch: instruction fetch unit with one outstanding memory read and a
// small {pc, data} buffer feeding the decode stage.
//
// Handshakes: imem side is a request/ack pair where imem_req and imem_addr
// hold steady until the cycle imem_ack=1 completes the read; the consumer
// side is valid/ready, a pop happens in any cycle with inst_valid=1 and
// inst_ready=1, and inst_valid never depends on inst_ready.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        RST_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    input  logic        inst_ready,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        drain_addr_q, drain_addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        pc_mem_d   [DEPTH];
    logic [31:0]        data_mem_q [DEPTH];
    logic [31:0]        data_mem_d [DEPTH];

    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A redirect kills both the in-flight data and any same-cycle pop.
    assign push = (state_q == S_REQ) && imem_ack && !redirect_valid;
    assign pop  = (count_q != '0) && inst_ready && !redirect_valid;

    // State register.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; REQ keeps issuing back-to-back while the buffer has room.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!redirect_valid && (count_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        state_d = S_IDLE;
                    end else if (count_d < DEPTH_C) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; DRAIN keeps presenting the abandoned address until its ack.
    always_comb begin
        imem_req   = (state_q == S_REQ) || (state_q == S_DRAIN);
        imem_addr  = (state_q == S_DRAIN) ? drain_addr_q : fetch_pc_q;
        inst_valid = (count_q != '0);
        inst_pc    = pc_mem_q[head_q];
        inst_data  = data_mem_q[head_q];
        dbg_state  = state_q;
    end

    // Datapath next values: fetch pc, drain address, FIFO pointers and storage.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;
        pc_mem_d     = pc_mem_q;
        data_mem_d   = data_mem_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            if ((state_q == S_REQ) && !imem_ack) begin
                drain_addr_d = fetch_pc_q;
            end
        end else begin
            if (push) begin
                pc_mem_d[tail_q]   = fetch_pc_q;
                data_mem_d[tail_q] = imem_rdata;
                tail_d             = ptr_inc(tail_q);
                fetch_pc_d         = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= '0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            pc_mem_q     <= pc_mem_d;
            data_mem_q   <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
// tb_inst_fetch: directed scenarios for inst_fetch. The driver pushes the
// {pc, data} each accepted fetch should deliver into exp_q; an independent
// monitor pops and compares on every consumer handshake.
module tb_inst_fetch;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic        clk;
    logic        RST_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_ready;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .RST_n          (RST_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    // Holds reset two cycles, then releases it just after a rising edge.
    // The caller is then in the first cycle after release.
    task automatic apply_reset(input logic ack_v, input logic rdy_v);
        RST_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        RST_n      = 1'b1;
        imem_ack   = ack_v;
        inst_ready = rdy_v;
    endtask

    task automatic settle_and_drain(input string name);
        repeat (3) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [63:0] e;
        if (RST_n && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", {inst_pc, inst_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 64'(inst_pc), 64'(e[63:32]));
                check("sb_data", 64'(inst_data), 64'(e[31:0]));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        RST_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_ack       = 1'b1;
        inst_ready     = 1'b1;

        // Reset values while held in reset, with ack and ready already high.
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_pc", 64'(inst_pc), 64'd0);
        check("rst_data", 64'(inst_data), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        // Streaming: ack and ready every cycle -> addresses 0,4,8,... back to back.
        apply_reset(1'b1, 1'b1);
        @(negedge clk);
        check("stream_first_cycle_req", 64'(imem_req), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stream_req", 64'(imem_req), 64'd1);
            check("stream_addr", 64'(imem_addr), 64'(32'(4 * k)));
            if (k > 0) check("stream_valid", 64'(inst_valid), 64'd1);
            expect_fetch(32'(4 * k));
        end
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clk);
        check("stream_hold_addr", 64'(imem_addr), 64'h18);
        settle_and_drain("stream_drained");

        // Back-pressure: ready low fills both entries, req drops, fetch resumes at 8.
        apply_reset(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("full_addr0", 64'(imem_addr), 64'h0);
        expect_fetch(32'h0);
        @(negedge clk);
        check("full_addr4", 64'(imem_addr), 64'h4);
        expect_fetch(32'h4);
        @(negedge clk);
        check("full_req_drop", 64'(imem_req), 64'd0);
        check("full_valid", 64'(inst_valid), 64'd1);
        check("full_head_pc", 64'(inst_pc), 64'h0);
        @(negedge clk);
        check("full_req_still_low", 64'(imem_req), 64'd0);
        check("full_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        next_cycle();
        inst_ready = 1'b1;
        @(negedge clk);
        check("resume_req_c6", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("resume_req_c7", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'h8);
        expect_fetch(32'h8);
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clk);
        check("resume_next_addr", 64'(imem_addr), 64'hC);
        settle_and_drain("full_drained");

        // Redirect in IDLE to 0x10, then redirect to 0x200 while 0x10 is pending.
        apply_reset(1'b0, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        @(negedge clk);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("idle_redirect_no_req", 64'(imem_req), 64'd0);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        check("drain_req_addr", 64'(imem_addr), 64'h10);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("drain_state", 64'(dbg_state), 64'(ST_DRAIN));
        check("drain_hold1", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h10});
        next_cycle();
        @(negedge clk);
        check("drain_hold2", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h10});
        next_cycle();
        imem_ack = 1'b1;
        @(negedge clk);
        check("drain_ack_addr", 64'(imem_addr), 64'h10);
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clk);
        check("drain_no_push", 64'(inst_valid), 64'd0);
        check("drain_idle_req", 64'(imem_req), 64'd0);
        next_cycle();
        imem_ack = 1'b1;
        @(negedge clk);
        check("post_drain_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h200});
        expect_fetch(32'h200);
        next_cycle();
        imem_ack = 1'b0;
        settle_and_drain("drain_drained");

        // Redirect to 0x40 with count=2, ack high and a same-cycle pop.
        apply_reset(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        expect_fetch(32'h0);
        @(negedge clk);
        expect_fetch(32'h4);
        next_cycle();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        exp_q.delete();
        @(negedge clk);
        check("flush_pre_valid", 64'(inst_valid), 64'd1);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 64'(inst_valid), 64'd0);
        check("flush_state", 64'(dbg_state), 64'(ST_IDLE));
        check("flush_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("flush_next_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h40});
        expect_fetch(32'h40);
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clk);
        check("flush_addr44", 64'(imem_addr), 64'h44);
        // Redirect together with an ack in REQ: data dropped, back to IDLE.
        next_cycle();
        imem_ack       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        exp_q.delete();
        next_cycle();
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("ackredir_state", 64'(dbg_state), 64'(ST_IDLE));
        check("ackredir_no_push", 64'(inst_valid), 64'd0);
        next_cycle();
        imem_ack = 1'b1;
        @(negedge clk);
        check("ackredir_next_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h80});
        expect_fetch(32'h80);
        next_cycle();
        imem_ack = 1'b0;
        settle_and_drain("flush_drained");

        // Address wrap at the top of the 32-bit space.
        apply_reset(1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_idle_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("wrap_addr_top", 64'(imem_addr), 64'hFFFF_FFFC);
        expect_fetch(32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap_addr_zero", 64'(imem_addr), 64'h0);
        expect_fetch(32'h0);
        next_cycle();
        imem_ack = 1'b0;
        @(negedge clk);
        check("wrap_addr_four", 64'(imem_addr), 64'h4);
        settle_and_drain("wrap_drained");

        // Reset pulse while in DRAIN: outputs clear at once, fetch restarts at RESET_PC.
        apply_reset(1'b0, 1'b1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        @(negedge clk);
        check("rstdrain_req_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rstdrain_state", 64'(dbg_state), 64'(ST_DRAIN));
        #2;
        RST_n    = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("rstdrain_req", 64'(imem_req), 64'd0);
        check("rstdrain_valid", 64'(inst_valid), 64'd0);
        check("rstdrain_head", {inst_pc, inst_data}, 64'd0);
        check("rstdrain_state_idle", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        next_cycle();
        RST_n = 1'b1;
        @(negedge clk);
        check("restart_first_req", 64'(imem_req), 64'd0);
        check("restart_no_stale", 64'(inst_valid), 64'd0);
        @(negedge clk);
        check("restart_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0});
        expect_fetch(32'h0);
        next_cycle();
        imem_ack = 1'b0;
        settle_and_drain("restart_drained");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
